williams_nvram_ioctl: RTL and testbench
=======================================

# williams_nvram_ioctl

Bridge between the HPS ioctl channel and the Williams CMOS battery RAM (1024 × 4-bit) inside `williams2`. It serves HPS upload reads, returning the CMOS contents to be saved as a file, and HPS download writes, restoring a saved file into CMOS. This is the reading end of the same ioctl interface used for ROM download. CMOS access goes through a request/grant port so the game CPU keeps priority. The block also tracks unsaved CPU writes for autosave.

## Interface
Parameters:
- `NV_INDEX`, 8'd4: ioctl_index value selecting NVRAM transfers.
- `RAM_LAT`, 1: cycles from an accepted CMOS address to valid `cmos_rdata` (1..3).

Ports:
- `clock_12`  in  1: sole clock, 12 MHz system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `ioctl_upload`  in  1: HPS upload (save) session active.
- `ioctl_download`  in  1: HPS download session active.
- `ioctl_index`  in  8: transfer index.
- `ioctl_rd`  in  1: one-cycle read strobe.
- `ioctl_wr`  in  1: one-cycle write strobe.
- `ioctl_addr`  in  17: byte address.
- `ioctl_dout`  in  8: write data from HPS.
- `ioctl_din`  out  8: read data to HPS.
- `ioctl_wait`  out  1: HPS must hold off the next strobe while high.
- `cmos_req`  out  1: request for the CMOS port.
- `cmos_gnt`  in  1: port granted this cycle.
- `cmos_addr`  out  10: CMOS nibble address.
- `cmos_we`  out  1: CMOS write enable, valid only with `cmos_gnt`.
- `cmos_wdata`  out  4: CMOS write nibble.
- `cmos_rdata`  in  4: CMOS read nibble.
- `cpu_cmos_we`  in  1: game CPU wrote CMOS this cycle.
- `nvram_dirty`  out  1: CMOS modified since the last full save or load.
- `upload_done`  out  1: one-cycle pulse when the last byte has been read.

## Operation
- File format: 1024 bytes. Byte N maps to nibble N. Reads return {4'hF, nibble}. Writes store `ioctl_dout[3:0]`.
- Strobe acceptance requires all of:
  - `ioctl_index == NV_INDEX`;
  - `ioctl_rd & ioctl_upload`, or `ioctl_wr & ioctl_download`;
  - FSM in IDLE.
- Out-of-range address (≥1024):
  - Read: `ioctl_din` = 8'hFF next cycle, no wait.
  - Write: ignored, no wait.
- Strobes arriving while not in IDLE, or with a wrong index, are ignored. No state changes.
- FSM states:
  - IDLE: accepted strobe latches addr, data and direction, then → REQ.
  - REQ: `cmos_req`=1 and `cmos_addr` driven. When `cmos_gnt`=1: a write pulses `cmos_we` that cycle, then → DONE; a read → RDWAIT.
  - RDWAIT: counts RAM_LAT cycles, then captures `cmos_rdata` into `ioctl_din`, then → DONE.
  - DONE: drops `cmos_req`, `ioctl_wait` and `cmos_we`, fires `upload_done` if applicable, then → IDLE.
- Dirty flag:
  - Set by `cpu_cmos_we`.
  - Cleared when a read of address 1023 completes, or a write of address 1023 completes.
  - If set and clear occur in the same cycle, set wins.
- Bridge writes never set dirty.
- `upload_done` pulses on completion of a read of address 1023 only.

## Timing
- Reset values, applied asynchronously:
  - `ioctl_din`=8'h00, `ioctl_wait`=0, `cmos_req`=0, `cmos_we`=0, `cmos_addr`=0, `cmos_wdata`=0, `nvram_dirty`=0, `upload_done`=0.
  - FSM = IDLE.
- Asserting reset mid-transfer aborts it. No CMOS write may occur after reset asserts.
- Strobe at edge 0:
  - `ioctl_wait`=1 and `cmos_req`=1 from edge 1.
  - `cmos_addr` stable from edge 1 until the DONE edge.
- Grant sampled each REQ cycle. There is no timeout: with no grant, wait stays high indefinitely.
- Read with grant at edge g: `ioctl_din` valid at edge g+RAM_LAT+1, with `ioctl_wait` falling the same edge. With immediate grant and RAM_LAT=1, wait is high for 3 cycles.
- Write with grant at edge g: `cmos_we`=1 only during cycle g. `ioctl_wait` falls at g+1.
- `cmos_wdata` holds the latched nibble from edge 1 to DONE.
- `ioctl_din` holds its value until the next completed read.

## Test plan
- Reset with strobes toggling: all outputs at reset values. Release reset: IDLE, no `cmos_req`.
- Upload read, addr 5, CMOS[5]=4'hA, grant tied high, RAM_LAT=1: `ioctl_wait` high 3 cycles, then `ioctl_din`=8'hFA.
- Download write, addr 1023, data 8'h37, grant held low 10 cycles:
  - `cmos_req` high throughout;
  - single `cmos_we` with `cmos_wdata`=4'h7 on the grant cycle;
  - dirty cleared afterwards.
- `cpu_cmos_we` pulse, then full 1024-byte upload:
  - `nvram_dirty`=1 until byte 1023 is read;
  - `upload_done` pulses once;
  - `cpu_cmos_we` coincident with the final read leaves dirty=1.
- Wrong index (0) read, and read of addr 1024:
  - index 0: no `cmos_req`, `ioctl_din` unchanged;
  - addr 1024: `ioctl_din`=8'hFF, `ioctl_wait` never asserted.
- Reset asserted during REQ of a write: `cmos_we` never pulses, and CMOS contents are unchanged.

Source files
------------

// File: rtl/williams_nvram_ioctl.sv
// williams_nvram_ioctl
// Bridges the HPS ioctl save/load channel to the 1024 x 4-bit Williams CMOS
// battery RAM. One byte of the file maps to one nibble. CMOS access is made
// through a request/grant port so the game CPU always keeps priority. A dirty
// flag tracks CPU writes made since the last complete save or load.
module williams_nvram_ioctl #(
  parameter logic [7:0] NV_INDEX = 8'd4,
  parameter int         RAM_LAT  = 1
) (
  input  logic        clock_12,
  input  logic        reset_n,
  input  logic        ioctl_upload,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic        ioctl_wr,
  input  logic [16:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        cmos_req,
  input  logic        cmos_gnt,
  output logic [9:0]  cmos_addr,
  output logic        cmos_we,
  output logic [3:0]  cmos_wdata,
  input  logic [3:0]  cmos_rdata,
  input  logic        cpu_cmos_we,
  output logic        nvram_dirty,
  output logic        upload_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_RDWAIT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Read-latency counter reload; RDWAIT lasts RAM_LAT cycles.
  localparam logic [1:0] LAT_M1 = 2'(RAM_LAT - 1);
  localparam logic [9:0] LAST_ADDR = 10'h3FF;

  state_t      state_q, state_d;
  logic [7:0]  din_q, din_d;
  logic        wait_q, wait_d;
  logic        req_q, req_d;
  logic [9:0]  addr_q, addr_d;
  logic [3:0]  wdata_q, wdata_d;
  logic        is_rd_q, is_rd_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        dirty_q, dirty_d;
  logic        done_q, done_d;

  logic        idx_ok;
  logic        rd_go;
  logic        wr_go;
  logic        in_range;
  logic        clr_dirty;

  assign idx_ok   = (ioctl_index == NV_INDEX);
  assign rd_go    = idx_ok & ioctl_rd & ioctl_upload;
  assign wr_go    = idx_ok & ioctl_wr & ioctl_download;
  assign in_range = (ioctl_addr[16:10] == 7'd0);

  // Next-state and next-output logic for the transfer sequencer and dirty flag.
  always_comb begin
    state_d   = state_q;
    din_d     = din_q;
    wait_d    = wait_q;
    req_d     = req_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_rd_d   = is_rd_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    clr_dirty = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rd_go || wr_go) begin
          if (in_range) begin
            addr_d  = ioctl_addr[9:0];
            wdata_d = ioctl_dout[3:0];
            is_rd_d = rd_go;
            wait_d  = 1'b1;
            req_d   = 1'b1;
            state_d = S_REQ;
          end else if (rd_go) begin
            // Bytes past the end of the CMOS image read as erased flash.
            din_d = 8'hFF;
          end
        end
      end
      S_REQ: begin
        if (cmos_gnt) begin
          cnt_d   = LAT_M1;
          state_d = is_rd_q ? S_RDWAIT : S_DONE;
        end
      end
      S_RDWAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_DONE: begin
        wait_d  = 1'b0;
        req_d   = 1'b0;
        state_d = S_IDLE;
        if (is_rd_q) begin
          din_d = {4'hF, cmos_rdata};
        end
        // The last byte of a save or a load marks the image as in sync.
        if (addr_q == LAST_ADDR) begin
          clr_dirty = 1'b1;
          done_d    = is_rd_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A CPU write in the same cycle as the final byte keeps the flag set.
    if (cpu_cmos_we) begin
      dirty_d = 1'b1;
    end else if (clr_dirty) begin
      dirty_d = 1'b0;
    end else begin
      dirty_d = dirty_q;
    end
  end

  // State and registered outputs; reset aborts any transfer in flight.
  always_ff @(posedge clock_12 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      din_q   <= 8'h00;
      wait_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= 10'd0;
      wdata_q <= 4'd0;
      is_rd_q <= 1'b0;
      cnt_q   <= 2'd0;
      dirty_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_rd_q <= is_rd_d;
      cnt_q   <= cnt_d;
      dirty_q <= dirty_d;
      done_q  <= done_d;
    end
  end

  // The write strobe follows the grant combinationally so it lands exactly on
  // the granted cycle; the reset-cleared state keeps it low during reset.
  assign cmos_we     = (state_q == S_REQ) & ~is_rd_q & cmos_gnt;

  assign ioctl_din   = din_q;
  assign ioctl_wait  = wait_q;
  assign cmos_req    = req_q;
  assign cmos_addr   = addr_q;
  assign cmos_wdata  = wdata_q;
  assign nvram_dirty = dirty_q;
  assign upload_done = done_q;

endmodule

// File: tb/tb_williams_nvram_ioctl.sv
// Bench for williams_nvram_ioctl: directed transfers against a CMOS RAM model,
// with a scoreboard monitor comparing completed reads and CMOS writes.
module tb_williams_nvram_ioctl;

  localparam logic [7:0] NV = 8'd4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_upload, ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd, ioctl_wr;
  logic [16:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        cmos_req;
  logic        cmos_gnt;
  logic [9:0]  cmos_addr;
  logic        cmos_we;
  logic [3:0]  cmos_wdata;
  logic [3:0]  cmos_rdata;
  logic        cpu_cmos_we;
  logic        nvram_dirty;
  logic        upload_done;

  always #5 clk = ~clk;

  williams_nvram_ioctl #(.NV_INDEX(NV), .RAM_LAT(1)) dut (
    .clock_12(clk), .reset_n(reset_n),
    .ioctl_upload(ioctl_upload), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait), .cmos_req(cmos_req), .cmos_gnt(cmos_gnt),
    .cmos_addr(cmos_addr), .cmos_we(cmos_we), .cmos_wdata(cmos_wdata),
    .cmos_rdata(cmos_rdata), .cpu_cmos_we(cpu_cmos_we),
    .nvram_dirty(nvram_dirty), .upload_done(upload_done)
  );

  typedef struct packed {
    logic       is_rd;
    logic [7:0] din;
  } exp_t;

  exp_t        exp_q[$];
  logic [13:0] we_q[$];
  logic [3:0]  mem [1024];
  logic [3:0]  exp_mem [1024];
  logic        ram_ready = 1'b0;
  logic        prev_wait = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_done = 0;
  int          w;
  int          done0;

  function automatic logic [3:0] pat(input int i);
    if (i == 5) return 4'hA;
    return 4'((i * 7) + 3);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CMOS RAM model: one-cycle registered read, write on we with grant.
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
      ram_ready <= 1'b1;
    end else begin
      if (cmos_we && cmos_gnt) mem[cmos_addr] <= cmos_wdata;
      cmos_rdata <= mem[cmos_addr];
    end
  end

  // Scoreboard monitor: CMOS writes and completed transfers.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_wait <= 1'b0;
    end else begin
      if (cmos_we) begin
        if (we_q.size() == 0) begin
          check("unexpected_cmos_we", {22'd0, cmos_addr}, 32'hFFFF_FFFF);
        end else begin
          logic [13:0] e;
          e = we_q.pop_front();
          check("cmos_write", {18'd0, cmos_addr, cmos_wdata}, {18'd0, e});
        end
      end
      if (prev_wait && !ioctl_wait) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.is_rd) check("read_din", {24'd0, ioctl_din}, {24'd0, e.din});
        end
      end
      if (upload_done) n_done <= n_done + 1;
      prev_wait <= ioctl_wait;
    end
  end

  task automatic do_xfer(input bit is_rd, input logic [7:0] idx, input int addr,
                         input logic [7:0] data, output int wcyc);
    if (idx == NV && addr < 1024) begin
      if (is_rd) begin
        exp_q.push_back({1'b1, 4'hF, exp_mem[addr]});
      end else begin
        exp_q.push_back({1'b0, 8'h00});
        we_q.push_back({10'(addr), data[3:0]});
        exp_mem[addr] = data[3:0];
      end
    end
    @(posedge clk); #1;
    ioctl_index    = idx;
    ioctl_addr     = 17'(addr);
    ioctl_dout     = data;
    ioctl_rd       = is_rd;
    ioctl_wr       = !is_rd;
    ioctl_upload   = is_rd;
    ioctl_download = !is_rd;
    @(posedge clk); #1;
    ioctl_rd = 1'b0;
    ioctl_wr = 1'b0;
    wcyc = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!ioctl_wait) return;
      wcyc++;
    end
    check("wait_timeout", 32'd1, 32'd0);
  endtask

  task automatic cpu_pulse();
    @(posedge clk); #1 cpu_cmos_we = 1'b1;
    @(posedge clk); #1 cpu_cmos_we = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    ioctl_upload = 1'b0; ioctl_download = 1'b0; ioctl_index = NV;
    ioctl_rd = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    cmos_gnt = 1'b1; cpu_cmos_we = 1'b0;
    for (int i = 0; i < 1024; i++) exp_mem[i] = pat(i);

    // Reset with strobes toggling
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      ioctl_rd = 1'($urandom); ioctl_wr = 1'($urandom);
      ioctl_upload = 1'($urandom); ioctl_download = 1'($urandom);
      ioctl_addr = 17'($urandom_range(0, 2047));
      @(negedge clk);
      check("reset_outputs", {5'd0, ioctl_din, ioctl_wait, cmos_req, cmos_we, cmos_addr,
                              cmos_wdata, nvram_dirty, upload_done}, 32'd0);
    end
    @(posedge clk); #1;
    ioctl_rd = 1'b0; ioctl_wr = 1'b0; ioctl_upload = 1'b0; ioctl_download = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_after_reset", {30'd0, cmos_req, ioctl_wait}, 32'd0);
    end

    // Read of address 5 with immediate grant
    do_xfer(1'b1, NV, 5, 8'h00, w);
    check("rd5_wait_cycles", 32'(w), 32'd3);
    // Write then read back address 200
    do_xfer(1'b0, NV, 200, 8'h5C, w);
    check("wr200_wait_cycles", 32'(w), 32'd2);
    do_xfer(1'b1, NV, 200, 8'h00, w);

    // Write of 1023 with grant held low 10 cycles, dirty cleared
    cpu_pulse();
    @(negedge clk);
    check("dirty_set_by_cpu", {31'd0, nvram_dirty}, 32'd1);
    cmos_gnt = 1'b0;
    fork
      do_xfer(1'b0, NV, 1023, 8'h37, w);
      begin
        repeat (2) @(posedge clk);
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check("req_held_no_grant", {30'd0, cmos_req, cmos_we}, 32'd2);
        end
        @(posedge clk); #1 cmos_gnt = 1'b1;
      end
    join
    check("wr1023_wait_cycles", 32'(w), 32'd12);
    check("dirty_cleared_by_load", {31'd0, nvram_dirty}, 32'd0);

    // Full 1024-byte upload after a CPU write
    cpu_pulse();
    done0 = n_done;
    for (int i = 0; i < 1024; i++) begin
      do_xfer(1'b1, NV, i, 8'h00, w);
      if (i % 128 == 0 || i == 1022)
        check("dirty_during_upload", {31'd0, nvram_dirty}, 32'd1);
    end
    check("dirty_after_upload", {31'd0, nvram_dirty}, 32'd0);
    repeat (2) @(negedge clk);
    check("upload_done_once", 32'(n_done - done0), 32'd1);

    // CPU write coincident with the final read keeps dirty
    cpu_pulse();
    fork
      do_xfer(1'b1, NV, 1023, 8'h00, w);
      begin
        repeat (4) @(posedge clk);
        #1 cpu_cmos_we = 1'b1;
        @(posedge clk); #1 cpu_cmos_we = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    check("dirty_set_wins", {31'd0, nvram_dirty}, 32'd1);
    check("upload_done_again", 32'(n_done - done0), 32'd2);

    // Wrong index is ignored
    do_xfer(1'b1, 8'd0, 5, 8'h00, w);
    check("wrong_idx_wait", 32'(w), 32'd0);
    repeat (2) begin
      check("wrong_idx_no_req", {31'd0, cmos_req}, 32'd0);
      @(negedge clk);
    end
    check("wrong_idx_din_kept", {24'd0, ioctl_din}, 32'h0000_00F7);

    // Out-of-range read
    do_xfer(1'b1, NV, 1024, 8'h00, w);
    check("oor_no_wait", 32'(w), 32'd0);
    check("oor_din", {24'd0, ioctl_din}, 32'h0000_00FF);

    // Reset asserted while a write waits for grant
    cmos_gnt = 1'b0;
    @(posedge clk); #1;
    ioctl_index = NV; ioctl_wr = 1'b1; ioctl_download = 1'b1;
    ioctl_addr = 17'd100; ioctl_dout = 8'h03;
    @(posedge clk); #1;
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    @(negedge clk);
    check("abort_req_before_reset", {31'd0, cmos_req}, 32'd1);
    #2 reset_n = 1'b0;
    cmos_gnt = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("abort_quiet_in_reset", {29'd0, cmos_req, cmos_we, ioctl_wait}, 32'd0);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_we_after", {31'd0, cmos_we}, 32'd0);
    end
    check("abort_mem_unchanged", {28'd0, mem[100]}, {28'd0, exp_mem[100]});

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size() + we_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
